frontend_testgen: RTL and testbench

FRONTEND_TESTGEN -- requirements
Module: frontend_testgen

---
 rtl/frontend_testgen_if.sv | 31 +++
 rtl/frontend_testgen.sv | 185 ++++++++++++++++++
 tb/tb_frontend_testgen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_testgen_if.sv
// Signal bundle for frontend_testgen: control inputs, upstream PCM channels and output samples.
interface frontend_testgen_if #(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 16
);
  logic              run;
  logic [DIV_W-1:0]  smp_div;
  logic [DATA_W-1:0] incr;
  logic [2:0]        mode;
  logic              l_pcm_valid;
  logic              r_pcm_valid;
  logic [DATA_W-1:0] l_pcm_data;
  logic [DATA_W-1:0] r_pcm_data;
  logic              smp_strobe;
  logic              l_out_valid;
  logic              r_out_valid;
  logic [DATA_W-1:0] l_out_data;
  logic [DATA_W-1:0] r_out_data;

  modport master (
    output run, smp_div, incr, mode,
    output l_pcm_valid, r_pcm_valid, l_pcm_data, r_pcm_data,
    input  smp_strobe, l_out_valid, r_out_valid, l_out_data, r_out_data
  );

  modport slave (
    input  run, smp_div, incr, mode,
    input  l_pcm_valid, r_pcm_valid, l_pcm_data, r_pcm_data,
    output smp_strobe, l_out_valid, r_out_valid, l_out_data, r_out_data
  );
endinterface

// File: rtl/frontend_testgen.sv
// Audio front-end test generator: PCM pass-through or DC/triangle/saw/square/silence on a divided strobe.
// Define FRONTEND_TESTGEN_NOISE_EN to add a 32-bit Galois LFSR noise source on mode 6.
module frontend_testgen #(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  frontend_testgen_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_DCP   = 3'd1,
    MODE_DCN   = 3'd2,
    MODE_TRI   = 3'd3,
    MODE_SAW   = 3'd4,
    MODE_SQR   = 3'd5,
    MODE_NOISE = 3'd6,
    MODE_SIL   = 3'd7
  } mode_e;

  localparam logic [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic signed [DATA_W+1:0] MAX_EXT = {2'b00, MAX};
  localparam logic signed [DATA_W+1:0] MIN_EXT = {2'b11, MIN};

  logic [DIV_W-1:0]  count_q, count_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              dir_up_q, dir_up_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  logic              l_valid_q, l_valid_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] l_data_q, l_data_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic signed [DATA_W+1:0] acc_ext, incr_ext, sum_up, sum_dn;
  logic [DATA_W-1:0] gen_val;
  mode_e             mode;

`ifdef FRONTEND_TESTGEN_NOISE_EN
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [DATA_W-1:0] SIGN_ONLY = {1'b1, {(DATA_W-1){1'b0}}};
  logic [31:0] lfsr_q, lfsr_d;
`endif

  assign mode = mode_e'(bus.mode);

  // Triangle sums carry two extra bits so overshoot past MAX/MIN is visible before clamping.
  always_comb begin
    acc_ext  = {{2{acc_q[DATA_W-1]}}, acc_q};
    incr_ext = {2'b00, bus.incr};
    sum_up   = acc_ext + incr_ext;
    sum_dn   = acc_ext - incr_ext;
  end

  always_comb begin
    count_d   = count_q;
    strobe_d  = 1'b0;
    acc_d     = acc_q;
    dir_up_d  = dir_up_q;
    phase_d   = phase_q;
    l_valid_d = 1'b0;
    r_valid_d = 1'b0;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    gen_val   = '0;
`ifdef FRONTEND_TESTGEN_NOISE_EN
    lfsr_d    = lfsr_q;
`endif

    if (count_q >= bus.smp_div) begin
      count_d  = '0;
      strobe_d = 1'b1;
    end else begin
      count_d  = count_q + DIV_W'(1);
    end

    // Generators advance on every strobe whatever the mode, so switching modes never restarts them.
    if (strobe_q) begin
      phase_d = phase_q + bus.incr;
      if (dir_up_q) begin
        if (sum_up > MAX_EXT) begin
          acc_d    = MAX;
          dir_up_d = 1'b0;
        end else begin
          acc_d    = sum_up[DATA_W-1:0];
        end
      end else begin
        if (sum_dn < MIN_EXT) begin
          acc_d    = MIN;
          dir_up_d = 1'b1;
        end else begin
          acc_d    = sum_dn[DATA_W-1:0];
        end
      end
`ifdef FRONTEND_TESTGEN_NOISE_EN
      lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_TAPS : 32'h0);
`endif
    end

    case (mode)
      MODE_DCP:   gen_val = MAX;
      MODE_DCN:   gen_val = MIN;
      MODE_TRI:   gen_val = acc_d;
      MODE_SAW:   gen_val = phase_d;
      MODE_SQR:   gen_val = phase_d[DATA_W-1] ? MIN : MAX;
`ifdef FRONTEND_TESTGEN_NOISE_EN
      MODE_NOISE: gen_val = (lfsr_d[DATA_W-1:0] == SIGN_ONLY) ? MIN : lfsr_d[DATA_W-1:0];
      MODE_SIL:   gen_val = '0;
`else
      MODE_NOISE,
      MODE_SIL:   gen_val = '0;
`endif
      default:    gen_val = '0;
    endcase

    if (mode == MODE_PASS) begin
      l_valid_d = bus.l_pcm_valid;
      r_valid_d = bus.r_pcm_valid;
      if (bus.l_pcm_valid) l_data_d = bus.l_pcm_data;
      if (bus.r_pcm_valid) r_data_d = bus.r_pcm_data;
    end else begin
      l_valid_d = strobe_q;
      r_valid_d = strobe_q;
      if (strobe_q) begin
        l_data_d = gen_val;
        r_data_d = gen_val;
      end
    end

    // Dropping run returns everything to its reset image, discarding any sample in flight.
    if (!bus.run) begin
      count_d   = '0;
      strobe_d  = 1'b0;
      acc_d     = '0;
      dir_up_d  = 1'b1;
      phase_d   = '0;
      l_valid_d = 1'b0;
      r_valid_d = 1'b0;
      l_data_d  = '0;
      r_data_d  = '0;
`ifdef FRONTEND_TESTGEN_NOISE_EN
      lfsr_d    = 32'h0000_0001;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      strobe_q  <= 1'b0;
      acc_q     <= '0;
      dir_up_q  <= 1'b1;
      phase_q   <= '0;
      l_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      l_data_q  <= '0;
      r_data_q  <= '0;
`ifdef FRONTEND_TESTGEN_NOISE_EN
      lfsr_q    <= 32'h0000_0001;
`endif
    end else begin
      count_q   <= count_d;
      strobe_q  <= strobe_d;
      acc_q     <= acc_d;
      dir_up_q  <= dir_up_d;
      phase_q   <= phase_d;
      l_valid_q <= l_valid_d;
      r_valid_q <= r_valid_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
`ifdef FRONTEND_TESTGEN_NOISE_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign bus.smp_strobe  = strobe_q;
  assign bus.l_out_valid = l_valid_q;
  assign bus.r_out_valid = r_valid_q;
  assign bus.l_out_data  = l_data_q;
  assign bus.r_out_data  = r_data_q;

endmodule

// File: tb/tb_frontend_testgen.sv
// Scoreboard bench for frontend_testgen: stimulus queues expected samples, a monitor pops them on each out_valid.
module tb_frontend_testgen;

  localparam int DATA_W = 24;
  localparam int DIV_W  = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t lq[$];
  exp_t rq[$];

  logic clk;
  logic rst_n;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   b;
  int   n;
  logic [DATA_W-1:0] prevR;

  logic [DATA_W-1:0] triExp [6] = '{24'h200000, 24'h400000, 24'h600000, 24'h7FFFFF, 24'h5FFFFF, 24'h3FFFFF};
  logic [DATA_W-1:0] sqrExp [5] = '{24'h7FFFFF, 24'h800001, 24'h800001, 24'h7FFFFF, 24'h7FFFFF};
  logic [DATA_W-1:0] sawExp [6] = '{24'h300000, 24'h600000, 24'h900000, 24'hC00000, 24'hF00000, 24'h200000};
`ifdef FRONTEND_TESTGEN_NOISE_EN
  logic [DATA_W-1:0] noiseExp [3] = '{24'h000002, 24'h000004, 24'h000008};
`else
  logic [DATA_W-1:0] noiseExp [3] = '{24'h000000, 24'h000000, 24'h000000};
`endif

  frontend_testgen_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  frontend_testgen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expectBoth(input logic [DATA_W-1:0] d, input int c);
    lq.push_back('{d, c});
    rq.push_back('{d, c});
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pulse run low for one edge with new settings, confirm the clear, and return the clearing edge index.
  task automatic applyStimulus(input logic [2:0] m, input logic [DATA_W-1:0] inc,
                               input logic [DIV_W-1:0] div, output int base);
    bus.run     = 1'b0;
    bus.mode    = m;
    bus.incr    = inc;
    bus.smp_div = div;
    @(negedge clk);
    checkOutput("clr_l_valid", 32'(bus.l_out_valid), 32'h0);
    checkOutput("clr_r_valid", 32'(bus.r_out_valid), 32'h0);
    checkOutput("clr_l_data",  32'(bus.l_out_data),  32'h0);
    checkOutput("clr_r_data",  32'(bus.r_out_data),  32'h0);
    checkOutput("clr_strobe",  32'(bus.smp_strobe),  32'h0);
    bus.run = 1'b1;
    base = cyc;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (bus.l_out_valid === 1'b1) begin
      if (lq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL l_unexpected_valid: got valid with data 0x%0h, expected no valid (cycle %0d)",
                 bus.l_out_data, cyc);
      end else begin
        e = lq.pop_front();
        checkOutput("l_data",  32'(bus.l_out_data), 32'(e.data));
        checkOutput("l_cycle", 32'(cyc),            32'(e.cyc));
      end
    end
    if (bus.r_out_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL r_unexpected_valid: got valid with data 0x%0h, expected no valid (cycle %0d)",
                 bus.r_out_data, cyc);
      end else begin
        e = rq.pop_front();
        checkOutput("r_data",  32'(bus.r_out_data), 32'(e.data));
        checkOutput("r_cycle", 32'(cyc),            32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n           = 1'b1;
    bus.run         = 1'b1;
    bus.mode        = 3'd3;
    bus.incr        = 24'h200000;
    bus.smp_div     = 16'd3;
    bus.l_pcm_valid = 1'b0;
    bus.r_pcm_valid = 1'b0;
    bus.l_pcm_data  = '0;
    bus.r_pcm_data  = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_l_valid", 32'(bus.l_out_valid), 32'h0);
    checkOutput("rst_r_valid", 32'(bus.r_out_valid), 32'h0);
    checkOutput("rst_l_data",  32'(bus.l_out_data),  32'h0);
    checkOutput("rst_r_data",  32'(bus.r_out_data),  32'h0);
    checkOutput("rst_strobe",  32'(bus.smp_strobe),  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = cyc;

    // Triangle from reset, ramping into the MAX clamp and turning down.
    for (int k = 0; k < 6; k++) expectBoth(triExp[k], b + 5 + 4 * k);
    waitUntil(b + 25);

    // Run dropped mid-period: clears outputs, first new sample equals incr.
    applyStimulus(3'd3, 24'h200000, 16'd3, b);
    expectBoth(24'h200000, b + 5);
    waitUntil(b + 5);

    // Square wave from the shared phase.
    applyStimulus(3'd5, 24'h400000, 16'd3, b);
    for (int k = 0; k < 5; k++) expectBoth(sqrExp[k], b + 5 + 4 * k);
    waitUntil(b + 21);

    // Sawtooth with period 2, including modulo wrap.
    applyStimulus(3'd4, 24'h300000, 16'd1, b);
    for (int k = 0; k < 6; k++) expectBoth(sawExp[k], b + 3 + 2 * k);
    waitUntil(b + 13);

    // Strobe every cycle; DC+, DC-, silence, then pass-through with no pcm activity.
    applyStimulus(3'd1, 24'h000000, 16'd0, b);
    expectBoth(24'h7FFFFF, b + 2);
    expectBoth(24'h7FFFFF, b + 3);
    waitUntil(b + 3);
    bus.mode = 3'd2;
    expectBoth(24'h800001, b + 4);
    expectBoth(24'h800001, b + 5);
    waitUntil(b + 5);
    bus.mode = 3'd7;
    expectBoth(24'h000000, b + 6);
    expectBoth(24'h000000, b + 7);
    waitUntil(b + 7);
    bus.mode = 3'd0;
    waitUntil(b + 8);
    checkOutput("switch_l_valid", 32'(bus.l_out_valid), 32'h0);
    checkOutput("switch_r_valid", 32'(bus.r_out_valid), 32'h0);
    waitUntil(b + 9);

    // Divider lowered from 100 to 2 while the count sits at 50.
    applyStimulus(3'd6, 24'h000000, 16'd100, b);
    waitUntil(b + 50);
    checkOutput("div_strobe_before", 32'(bus.smp_strobe), 32'h0);
    bus.smp_div = 16'd2;
    for (int k = 0; k < 3; k++) expectBoth(noiseExp[k], b + 52 + 3 * k);
    waitUntil(b + 51);
    checkOutput("div_strobe_next", 32'(bus.smp_strobe), 32'h1);
    waitUntil(b + 52);
    checkOutput("div_strobe_width", 32'(bus.smp_strobe), 32'h0);
    waitUntil(b + 58);
    bus.mode = 3'd0;
    prevR = noiseExp[2];

    // Pass-through: independent channels, data captured only on own valid.
    n = b + 62;
    waitUntil(n);
    bus.l_pcm_valid = 1'b1;
    bus.l_pcm_data  = 24'h123456;
    bus.r_pcm_data  = 24'h555555;
    lq.push_back('{24'h123456, n + 1});
    rq.push_back('{24'hABCDEF, n + 3});
    waitUntil(n + 1);
    bus.l_pcm_valid = 1'b0;
    bus.l_pcm_data  = 24'h111111;
    checkOutput("pass_r_hold",  32'(bus.r_out_data),  32'(prevR));
    checkOutput("pass_r_quiet", 32'(bus.r_out_valid), 32'h0);
    waitUntil(n + 2);
    bus.r_pcm_valid = 1'b1;
    bus.r_pcm_data  = 24'hABCDEF;
    checkOutput("pass_l_pulse", 32'(bus.l_out_valid), 32'h0);
    checkOutput("pass_l_hold",  32'(bus.l_out_data),  32'h123456);
    waitUntil(n + 3);
    bus.r_pcm_valid = 1'b0;
    checkOutput("pass_l_keep", 32'(bus.l_out_data), 32'h123456);
    waitUntil(n + 4);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_l_data",  32'(bus.l_out_data),  32'h0);
    checkOutput("async_r_data",  32'(bus.r_out_data),  32'h0);
    checkOutput("async_l_valid", 32'(bus.l_out_valid), 32'h0);
    checkOutput("async_r_valid", 32'(bus.r_out_valid), 32'h0);
    checkOutput("async_strobe",  32'(bus.smp_strobe),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20 && (lq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
    checkOutput("l_queue_drained", 32'(lq.size()), 32'h0);
    checkOutput("r_queue_drained", 32'(rq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
